// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage in front of a one-cycle-latency synchronous instruction
//   memory. It issues sequential word addresses, captures the returning data
//   into a registered output (insn/insn_pc/insn_valid), and absorbs
//   decode-stage back-pressure with a one-entry skid buffer. This keeps
//   instructions in strict address order with none lost or duplicated.
//   A redirect restarts fetch at a new target and discards everything in flight.
//
// Ports
//   clock        : single clock, rising-edge
//   reset        : asynchronous, active-high
//   imem_addr    : word address presented to instruction memory
//   imem_rden    : read-issue strobe
//   imem_q       : memory data for the address issued one cycle earlier
//   stall        : decode cannot accept insn this cycle
//   redirect     : branch/jump redirect request
//   redirect_pc  : redirect target
//   insn         : registered instruction word
//   insn_pc      : address of insn
//   insn_valid   : insn/insn_pc hold a live instruction
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                 ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rden,
  input  logic [31:0]       imem_q,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       insn,
  output logic [ADDR_W-1:0] insn_pc,
  output logic              insn_valid
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state_q,       state_d;
  logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic              inflight_q,    inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [31:0]       skid_word_q,   skid_word_d;
  logic [ADDR_W-1:0] skid_pc_q,     skid_pc_d;
  logic              skid_full_q,   skid_full_d;
  logic [31:0]       insn_q,        insn_d;
  logic [ADDR_W-1:0] insn_pc_q,     insn_pc_d;
  logic              insn_valid_q,  insn_valid_d;
  logic              load_s;
  logic              issue_s;

  // Next-state, skid/output steering and memory issue.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_word_d   = skid_word_q;
    skid_pc_d     = skid_pc_q;
    skid_full_d   = skid_full_q;
    insn_d        = insn_q;
    insn_pc_d     = insn_pc_q;
    insn_valid_d  = insn_valid_q;
    issue_s       = 1'b0;
    imem_addr     = fetch_pc_q;
    // Output register may advance when decode takes the current word or
    // when there is nothing live in it.
    load_s        = !stall || !insn_valid_q;

    if (redirect) begin
      // Redirect beats stall: drop returning data, skid and output, and
      // issue the target immediately.
      issue_s       = 1'b1;
      imem_addr     = redirect_pc;
      fetch_pc_d    = redirect_pc + PC_ONE;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_pc;
      skid_full_d   = 1'b0;
      insn_valid_d  = 1'b0;
      state_d       = RUN;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
        end
        RUN, FULL: begin
          // Holding off issue while stalled with data already in flight
          // guarantees the skid never has to take a second word.
          issue_s = (state_q == RUN) && !(stall && insn_valid_q && inflight_q);

          if (load_s) begin
            if (skid_full_q) begin
              insn_d       = skid_word_q;
              insn_pc_d    = skid_pc_q;
              insn_valid_d = 1'b1;
              if (inflight_q) begin
                skid_word_d = imem_q;
                skid_pc_d   = inflight_pc_q;
              end else begin
                skid_full_d = 1'b0;
                state_d     = RUN;
              end
            end else if (inflight_q) begin
              insn_d       = imem_q;
              insn_pc_d    = inflight_pc_q;
              insn_valid_d = 1'b1;
            end else begin
              insn_valid_d = 1'b0;
            end
          end else if (inflight_q) begin
            skid_word_d = imem_q;
            skid_pc_d   = inflight_pc_q;
            skid_full_d = 1'b1;
            state_d     = FULL;
          end else begin
            state_d = state_q;
          end

          if (issue_s) begin
            imem_addr     = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + PC_ONE;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
          end else begin
            inflight_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    imem_rden = issue_s;
    // Memory interface is quiet and parked at RESET_PC while in reset.
    if (reset) begin
      imem_rden = 1'b0;
      imem_addr = RESET_PC;
    end else begin
      imem_rden = issue_s;
    end
  end

  // State, fetch pointer, in-flight tracking, skid and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_word_q   <= 32'h0000_0000;
      skid_pc_q     <= '0;
      skid_full_q   <= 1'b0;
      insn_q        <= 32'h0000_0000;
      insn_pc_q     <= '0;
      insn_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_word_q   <= skid_word_d;
      skid_pc_q     <= skid_pc_d;
      skid_full_q   <= skid_full_d;
      insn_q        <= insn_d;
      insn_pc_q     <= insn_pc_d;
      insn_valid_q  <= insn_valid_d;
    end
  end

  assign insn       = insn_q;
  assign insn_pc    = insn_pc_q;
  assign insn_valid = insn_valid_q;

endmodule
